// File: rtl/hybrid_adder_seq_pkg.sv
// Shared types and constants for the slice-serial hybrid adder.
// State encoding, index-width helper and default geometry live here.
package hybrid_adder_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_GROUP = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hybrid_adder_seq_if.sv
// Request/response bundle for the slice-serial adder.
// The requester owns start and the operands; the adder owns status and results.
interface hybrid_adder_seq_if
    import hybrid_adder_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, x, y, cin, sub,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, x, y, cin, sub,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/hybrid_adder_seq_cla_group.sv
// Combinational GROUP-bit carry-lookahead slice.
// Every carry is a flat sum of products of g/p terms and ci, with no ripple.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] sum,
    output logic             co,
    output logic             c_msb
);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < GROUP; gi++) begin : g_bit
            assign g[gi]   = a[gi] & b[gi];
            assign p[gi]   = a[gi] ^ b[gi];
            assign sum[gi] = p[gi] ^ c[gi];
        end

        for (genvar gi = 1; gi <= GROUP; gi++) begin : g_carry
            logic c_bit;
            always_comb begin
                logic term;
                term  = 1'b0;
                c_bit = ci & (&p[gi-1:0]);
                for (int k = 0; k < gi; k++) begin
                    term = g[k];
                    for (int m = k + 1; m < gi; m++) begin
                        term = term & p[m];
                    end
                    c_bit = c_bit | term;
                end
            end
            assign c[gi] = c_bit;
        end
    endgenerate

    assign co    = c[GROUP];
    assign c_msb = c[GROUP-1];
endmodule

// File: rtl/hybrid_adder_seq.sv
// Multi-cycle adder/subtractor: one CLA slice per clock, carry held in a register.
// Results update only on entry to DONE and hold until the next operation completes.
module hybrid_adder_seq
    import hybrid_adder_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic               clk,
    input  logic               rst_n,
    hybrid_adder_seq_if.slave  bus
);
    localparam int NGROUPS = WIDTH / GROUP;
    localparam int IDXW    = (clog2(NGROUPS) < 1) ? 1 : clog2(NGROUPS);

    state_t           state_reg, state_next;
    logic [IDXW-1:0]  idx_reg;
    logic [WIDTH-1:0] x_reg, y_reg, sum_reg, sum_next, s_reg;
    logic             carry_reg, cout_reg, ovf_reg, busy_reg, done_reg;
    logic             accept, last_slice;

    logic [GROUP-1:0] x_slices [NGROUPS];
    logic [GROUP-1:0] y_slices [NGROUPS];
    logic [GROUP-1:0] slice_sum;
    logic             slice_co, slice_c_msb;

    generate
        for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_slice
            assign x_slices[gi] = x_reg[gi*GROUP +: GROUP];
            assign y_slices[gi] = y_reg[gi*GROUP +: GROUP];
        end
    endgenerate

    cla_group #(.GROUP(GROUP)) u_cla (
        .a     (x_slices[idx_reg]),
        .b     (y_slices[idx_reg]),
        .ci    (carry_reg),
        .sum   (slice_sum),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_slice = (idx_reg == IDXW'(NGROUPS - 1));
        unique case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_ADD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (last_slice) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Splice the current slice result into the partial sum.
    always_comb begin
        sum_next = sum_reg;
        for (int i = 0; i < NGROUPS; i++) begin
            if (idx_reg == IDXW'(i)) begin
                sum_next[i*GROUP +: GROUP] = slice_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            sum_reg   <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == ST_ADD);
            done_reg  <= (state_next == ST_DONE);
            if (accept) begin
                x_reg     <= bus.x;
                y_reg     <= bus.y ^ {WIDTH{bus.sub}};
                carry_reg <= bus.cin ^ bus.sub;
                idx_reg   <= '0;
            end else if (state_reg == ST_ADD) begin
                sum_reg   <= sum_next;
                carry_reg <= slice_co;
                idx_reg   <= idx_reg + IDXW'(1);
                if (last_slice) begin
                    s_reg    <= sum_next;
                    cout_reg <= slice_co;
                    ovf_reg  <= slice_co ^ slice_c_msb;
                end
            end
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.s    = s_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: doc/hybrid_adder_seq.md
Name: hybrid_adder_seq

Overview:
- Parametrised, multi-cycle successor to the team's fixed 8-bit hybrid adder.
- Adds or subtracts two WIDTH-bit operands one GROUP-bit carry-lookahead slice per clock, carrying between slices through a register.
- Start/busy/done handshake; reports carry-out and signed overflow.
- Used where area matters more than latency, e.g. datapath accumulators and address arithmetic.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP.
- GROUP, 4, bits per CLA slice processed each cycle; must be 2 or more.
- NGROUPS, WIDTH/GROUP, derived local constant; not overridable.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request an operation; sampled only in IDLE or DONE.
- x  input  WIDTH  operand A; captured when start is accepted.
- y  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- sub  input  1  1 = subtract; captured when start is accepted.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse: results valid.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (rst_n low at an edge): state IDLE; busy, done, s, cout and ovf all 0; slice index, carry and operand registers cleared. Reset takes priority over every other event, including mid-operation: the operation is abandoned and no done is produced.
- Operand effect: eff_y = y XOR {WIDTH{sub}}; eff_cin = cin XOR sub.
  - sub=1, cin=0 gives x-y.
  - sub=1, cin=1 gives x-y-1 (borrow in).
- FSM states IDLE, ADD, DONE:
  - IDLE: start=1 latches x, eff_y, eff_cin; slice index <= 0; go to ADD. start=0: stay.
  - ADD: each edge computes slice idx (bits idx*GROUP+GROUP-1 : idx*GROUP) with the CLA group, using the carry register as carry-in. The slice result goes into the internal sum register; the slice carry-out goes into the carry register; idx increments. After slice NGROUPS-1, go to DONE and load s, cout and ovf.
  - DONE: lasts one cycle. start=1 is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Timing, with start high in cycle 0:
  - busy=1 in cycles 1..NGROUPS.
  - done=1 in cycle NGROUPS+1.
  - Total latency NGROUPS+1 cycles; throughput one operation per NGROUPS+1 cycles.
- busy and done are registered and never high together.
- s, cout and ovf change only on entry to DONE. They hold their values through IDLE and through the next operation until its DONE.
- ovf = (carry into bit WIDTH-1) XOR cout, captured from the final slice.
- start while in ADD is ignored; captured operands are unaffected by input changes after acceptance.
- Carry wrap: no carry feedback; the carry out of the last slice is cout, and the carry register is reloaded from eff_cin at each accepted start.
- x, y, cin and sub are don't-care except in the cycle start is accepted.

Decomposition:
- Shared package/header:
  - state encoding constants ST_IDLE, ST_ADD, ST_DONE (2 bits);
  - helper function clog2 for the index width;
  - default WIDTH/GROUP constants.
- One sub-module: cla_group, a purely combinational GROUP-bit carry-lookahead slice.
  - Inputs a, b, ci; outputs sum, co and c_msb (carry into the slice MSB, needed for ovf).
  - Generate/propagate terms per bit; all carries expanded from ci in two-level form.
- The top level holds the FSM, slice index counter, operand/sum/carry registers and the slice select multiplexers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, s=0000, cout=0, ovf=0; no operation starts.
- Full carry ripple (WIDTH=16, GROUP=4): x=FFFF, y=0001, cin=0, sub=0, start in cycle 0 -> busy in cycles 1-4, done=1 in cycle 5 only, s=0000, cout=1, ovf=0.
- Overflow and subtract:
  - x=7FFF + y=0001 -> s=8000, cout=0, ovf=1.
  - Then x=0005, y=0007, sub=1, cin=0 -> s=FFFE, cout=0, ovf=0.
  - sub=1, cin=1 with the same operands -> s=FFFD.
- Handshake: start pulsed in cycle 2 of an operation with different x/y -> ignored, result unchanged. start held high during the DONE cycle -> new operation accepted, busy in the next cycle, second done exactly 5 cycles after the first.
- Reset mid-operation: assert rst_n=0 in cycle 2 -> next cycle all outputs 0, no done pulse. A following x=1234 + y=4321 -> s=5555, cout=0.
- Regression at WIDTH=8, GROUP=2 (done in cycle 5):
  - FF+FE, cin=0 -> FD, cout=1.
  - AA+55 -> FF, cout=0.
  - 08+81, cin=1 -> 8A.
  - 01+00 -> 01.
  - F0+88 -> 78, cout=1, ovf=1.
